// File: rtl/riscv_pkg.sv
// Shared encodings for the pipeline: load/store width codes and the
// memory-stage FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the memory stage: store byte enables and
// lane replication, load extraction with extension, and access legality.
import riscv_pkg::*;

module mem_align (
  input  logic [1:0]  addrLo,
  input  logic [2:0]  funct3,
  input  logic [31:0] storeData,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic        illegal
);

  logic isByte;
  logic isHalf;
  logic isWord;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign isByte = (funct3 == F3_B) || (funct3 == F3_BU);
  assign isHalf = (funct3 == F3_H) || (funct3 == F3_HU);
  assign isWord = (funct3 == F3_W);

  assign illegal = !(isByte || isHalf || isWord)
                 || (isHalf && addrLo[0])
                 || (isWord && (addrLo != 2'b00));

  // Each lane picks the byte of storeData that a replicated pattern puts there.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        if (isByte) begin
          wdata[gi*8 +: 8] = storeData[7:0];
          be[gi]           = (addrLo == 2'(gi));
        end else if (isHalf) begin
          wdata[gi*8 +: 8] = storeData[(gi % 2)*8 +: 8];
          be[gi]           = (addrLo[1] == 1'(gi / 2));
        end else begin
          wdata[gi*8 +: 8] = storeData[gi*8 +: 8];
          be[gi]           = 1'b1;
        end
      end
    end
  endgenerate

  assign loadByte = rdata[{addrLo, 3'b000} +: 8];
  assign loadHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    loadData = rdata;
    if (isByte) begin
      loadData = funct3[2] ? {24'h0, loadByte} : {{24{loadByte[7]}}, loadByte};
    end else if (isHalf) begin
      loadData = funct3[2] ? {16'h0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory-access stage: issues data-memory requests over req/ack,
// stalls execute while busy and registers the writeback results.
import riscv_pkg::*;

module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_RegWrite,
  input  logic        in_MemToReg,
  input  logic [4:0]  in_RegDest,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        out_valid,
  output logic        out_RegWrite,
  output logic [4:0]  out_RegDest,
  output logic [31:0] out_wb_data,
  output logic        access_err
);

  mem_state_t stateReg;
  mem_state_t stateNext;

  logic [31:0] addrReg;
  logic [2:0]  funct3Reg;
  logic        regWriteReg;
  logic        memToRegReg;
  logic [4:0]  regDestReg;

  logic        accept;
  logic        isMem;
  logic        illegalIn;
  logic [1:0]  alignAddr;
  logic [2:0]  alignFunct3;
  logic [3:0]  alignBe;
  logic [31:0] alignWdata;
  logic [31:0] alignLoad;
  logic        alignIllegal;

  assign in_ready = (stateReg == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign isMem    = in_MemRead || in_MemWrite;

  // One aligner serves both phases: incoming op while idle, latched op while accessing.
  assign alignAddr   = in_ready ? alu_result[1:0] : addrReg[1:0];
  assign alignFunct3 = in_ready ? funct3 : funct3Reg;

  mem_align u_align (
    .addrLo    (alignAddr),
    .funct3    (alignFunct3),
    .storeData (store_data),
    .rdata     (dmem_rdata),
    .be        (alignBe),
    .wdata     (alignWdata),
    .loadData  (alignLoad),
    .illegal   (alignIllegal)
  );

  assign illegalIn = isMem && (alignIllegal || (in_MemRead && in_MemWrite));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= ST_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:   if (accept && isMem && !illegalIn) stateNext = ST_ACCESS;
      ST_ACCESS: if (dmem_ack) stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_be      <= 4'h0;
      out_valid    <= 1'b0;
      out_RegWrite <= 1'b0;
      out_RegDest  <= 5'd0;
      out_wb_data  <= 32'h0;
      access_err   <= 1'b0;
      addrReg      <= 32'h0;
      funct3Reg    <= 3'b000;
      regWriteReg  <= 1'b0;
      memToRegReg  <= 1'b0;
      regDestReg   <= 5'd0;
    end else begin
      out_valid  <= 1'b0;
      access_err <= 1'b0;
      if (stateReg == ST_IDLE) begin
        if (accept) begin
          if (!isMem || illegalIn) begin
            out_valid    <= 1'b1;
            access_err   <= illegalIn;
            out_RegWrite <= in_RegWrite && !illegalIn;
            out_RegDest  <= in_RegDest;
            out_wb_data  <= alu_result;
          end else begin
            addrReg     <= alu_result;
            funct3Reg   <= funct3;
            regWriteReg <= in_RegWrite;
            memToRegReg <= in_MemToReg;
            regDestReg  <= in_RegDest;
            dmem_req    <= 1'b1;
            dmem_we     <= in_MemWrite;
            dmem_addr   <= {alu_result[31:2], 2'b00};
            dmem_be     <= alignBe;
            dmem_wdata  <= alignWdata;
          end
        end
      end else if (dmem_ack) begin
        dmem_req     <= 1'b0;
        out_valid    <= 1'b1;
        out_RegWrite <= regWriteReg;
        out_RegDest  <= regDestReg;
        out_wb_data  <= memToRegReg ? alignLoad : addrReg;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
`timescale 1ns/1ps

module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        in_MemRead;
  logic        in_MemWrite;
  logic        in_RegWrite;
  logic        in_MemToReg;
  logic [4:0]  in_RegDest;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        out_valid;
  logic        out_RegWrite;
  logic [4:0]  out_RegDest;
  logic [31:0] out_wb_data;
  logic        access_err;

  int tests;
  int fails;

  // Stream monitor for the back-to-back scenario
  logic        monEn;
  int          outCount;
  logic [31:0] wbLog [0:15];

  memory_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .funct3       (funct3),
    .in_MemRead   (in_MemRead),
    .in_MemWrite  (in_MemWrite),
    .in_RegWrite  (in_RegWrite),
    .in_MemToReg  (in_MemToReg),
    .in_RegDest   (in_RegDest),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .out_valid    (out_valid),
    .out_RegWrite (out_RegWrite),
    .out_RegDest  (out_RegDest),
    .out_wb_data  (out_wb_data),
    .access_err   (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (monEn && out_valid) begin
      if (outCount < 16) wbLog[outCount] <= out_wb_data;
      outCount <= outCount + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    alu_result  = 32'h0;
    store_data  = 32'h0;
    funct3      = 3'b000;
    in_MemRead  = 1'b0;
    in_MemWrite = 1'b0;
    in_RegWrite = 1'b0;
    in_MemToReg = 1'b0;
    in_RegDest  = 5'd0;
  endtask

  task automatic drive_op(input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [2:0] f3, input logic rd, input logic wr,
                          input logic rw, input logic m2r, input logic [4:0] dest);
    in_valid    = 1'b1;
    alu_result  = addr;
    store_data  = sdata;
    funct3      = f3;
    in_MemRead  = rd;
    in_MemWrite = wr;
    in_RegWrite = rw;
    in_MemToReg = m2r;
    in_RegDest  = dest;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    monEn = 1'b0;
    outCount = 0;
    idle_inputs();
    tick();
    tick();
    tests++;
    if ({dmem_req, dmem_we, out_valid, out_RegWrite, access_err} !== 5'b0 ||
        dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_be !== 4'h0 ||
        out_wb_data !== 32'h0 || out_RegDest !== 5'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: req=%b we=%b ov=%b rw=%b err=%b addr=%h wd=%h be=%b wb=%h rd=%0d rdy=%b, required all zero and in_ready=1",
               dmem_req, dmem_we, out_valid, out_RegWrite, access_err, dmem_addr,
               dmem_wdata, dmem_be, out_wb_data, out_RegDest, in_ready);
    end
    rst = 1'b0;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_nonmem();
    drive_op(32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
    tick();
    idle_inputs();
    tests++;
    if (out_valid !== 1'b1 || out_wb_data !== 32'h1234 || out_RegDest !== 5'd5 ||
        out_RegWrite !== 1'b1 || dmem_req !== 1'b0 || access_err !== 1'b0) begin
      fails++;
      $display("FAIL nonmem_retire: ov=%b wb=%h rd=%0d rw=%b req=%b err=%b, required 1 00001234 5 1 0 0",
               out_valid, out_wb_data, out_RegDest, out_RegWrite, dmem_req, access_err);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL nonmem_pulse: out_valid=%b, required 0", out_valid);
    end
    $display("[TB] nonmem alu=00001234 -> wb=%h", 32'h1234);
  endtask

  task automatic test_store();
    int k;
    // SB 0x103 with two wait cycles
    drive_op(32'h0000_0103, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    idle_inputs();
    tests++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h100 ||
        dmem_be !== 4'b1000 || dmem_wdata !== 32'hDDDD_DDDD) begin
      fails++;
      $display("FAIL sb_request: req=%b we=%b addr=%h be=%b wd=%h, required 1 1 00000100 1000 dddddddd",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    for (k = 0; k < 3; k++) begin
      tests++;
      if (dmem_req !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
          dmem_be !== 4'b1000 || dmem_wdata !== 32'hDDDD_DDDD) begin
        fails++;
        $display("FAIL sb_hold%0d: req=%b rdy=%b ov=%b be=%b wd=%h, required 1 0 0 1000 dddddddd",
                 k, dmem_req, in_ready, out_valid, dmem_be, dmem_wdata);
      end
      if (k == 2) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || dmem_req !== 1'b0 || out_RegWrite !== 1'b0 ||
        access_err !== 1'b0 || in_ready !== 1'b1 || out_wb_data !== 32'h103) begin
      fails++;
      $display("FAIL sb_retire: ov=%b req=%b rw=%b err=%b rdy=%b wb=%h, required 1 0 0 0 1 00000103",
               out_valid, dmem_req, out_RegWrite, access_err, in_ready, out_wb_data);
    end
    $display("[TB] SB addr=00000103 be=1000 wdata=dddddddd");

    // SH 0x102, immediate ack
    drive_op(32'h0000_0102, 32'h1122_CCDD, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    idle_inputs();
    tests++;
    if (dmem_req !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hCCDD_CCDD ||
        dmem_addr !== 32'h100) begin
      fails++;
      $display("FAIL sh_request: req=%b be=%b wd=%h addr=%h, required 1 1100 ccddccdd 00000100",
               dmem_req, dmem_be, dmem_wdata, dmem_addr);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    $display("[TB] SH addr=00000102 be=1100 wdata=ccddccdd");

    // SW 0x204, immediate ack
    drive_op(32'h0000_0204, 32'h1234_5678, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    idle_inputs();
    tests++;
    if (dmem_req !== 1'b1 || dmem_be !== 4'b1111 || dmem_wdata !== 32'h1234_5678 ||
        dmem_addr !== 32'h204) begin
      fails++;
      $display("FAIL sw_request: req=%b be=%b wd=%h addr=%h, required 1 1111 12345678 00000204",
               dmem_req, dmem_be, dmem_wdata, dmem_addr);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL sw_retire: ov=%b req=%b, required 1 0", out_valid, dmem_req);
    end
    $display("[TB] SW addr=00000204 be=1111 wdata=12345678");
  endtask

  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] expWb);
    drive_op(addr, 32'h0, f3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    tick();
    idle_inputs();
    tests++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {addr[31:2], 2'b00}) begin
      fails++;
      $display("FAIL %s_request: req=%b we=%b addr=%h, required 1 0 %h",
               name, dmem_req, dmem_we, dmem_addr, {addr[31:2], 2'b00});
    end
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    tests++;
    if (out_valid !== 1'b1 || out_wb_data !== expWb || out_RegWrite !== 1'b1 ||
        out_RegDest !== 5'd9 || access_err !== 1'b0) begin
      fails++;
      $display("FAIL %s_data: ov=%b wb=%h rw=%b rd=%0d err=%b, required 1 %h 1 9 0",
               name, out_valid, out_wb_data, out_RegWrite, out_RegDest, access_err, expWb);
    end
    $display("[TB] %s addr=%h rdata=%h -> wb=%h", name, addr, rdata, expWb);
  endtask

  task automatic test_loads();
    do_load("lb",  3'b000, 32'h202, 32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h202, 32'h0080_0000, 32'h0000_0080);
    do_load("lhu", 3'b101, 32'h202, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lh",  3'b001, 32'h200, 32'h1234_8001, 32'hFFFF_8001);
    do_load("lw",  3'b010, 32'h208, 32'hCAFE_F00D, 32'hCAFE_F00D);
  endtask

  task automatic do_illegal(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic rd, input logic wr);
    drive_op(addr, 32'hFFFF_FFFF, f3, rd, wr, 1'b1, rd, 5'd3);
    tick();
    idle_inputs();
    tests++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b1 || access_err !== 1'b1 ||
        out_RegWrite !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: req=%b ov=%b err=%b rw=%b rdy=%b, required 0 1 1 0 1",
               name, dmem_req, out_valid, access_err, out_RegWrite, in_ready);
    end
    tick();
    tests++;
    if (access_err !== 1'b0 || out_valid !== 1'b0 || dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL %s_pulse: err=%b ov=%b req=%b, required 0 0 0",
               name, access_err, out_valid, dmem_req);
    end
    $display("[TB] illegal %s addr=%h f3=%b -> access_err", name, addr, f3);
  endtask

  task automatic test_illegal();
    do_illegal("lw_misaligned", 3'b010, 32'h101, 1'b1, 1'b0);
    do_illegal("sh_misaligned", 3'b001, 32'h203, 1'b0, 1'b1);
    do_illegal("bad_funct3",    3'b011, 32'h200, 1'b1, 1'b0);
    do_illegal("rd_and_wr",     3'b010, 32'h200, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_access();
    int k;
    drive_op(32'h0000_0300, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    tick();
    idle_inputs();
    tests++;
    if (dmem_req !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: req=%b, required 1", dmem_req);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: req=%b, required 0 immediately", dmem_req);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1 || dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_release: rdy=%b req=%b, required 1 0", in_ready, dmem_req);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555_5555;
    for (k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL rstmid_stray_ack%0d: ov=%b rdy=%b, required 0 1", k, out_valid, in_ready);
      end
    end
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    $display("[TB] reset during access dropped request");
  endtask

  task automatic test_back_to_back();
    int accepts;
    int waitCnt;
    logic [31:0] expWb [0:7];
    outCount = 0;
    monEn = 1'b1;
    accepts = 0;
    dmem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        drive_op(32'h10 + i, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'(i + 1));
        expWb[i] = 32'h10 + i;
      end else begin
        dmem_rdata = 32'hA000_0000 + i;
        drive_op(32'h300 + 4 * i, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'(i + 1));
        expWb[i] = 32'hA000_0000 + i;
      end
      waitCnt = 0;
      while (in_ready !== 1'b1 && waitCnt < 10) begin
        tick();
        waitCnt++;
      end
      if (waitCnt >= 10) begin
        tests++;
        fails++;
        $display("FAIL b2b_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waitCnt);
      end
      tick();
      accepts++;
    end
    idle_inputs();
    tick();
    tick();
    tick();
    dmem_ack = 1'b0;
    monEn = 1'b0;
    tests++;
    if (outCount !== accepts || accepts !== 8) begin
      fails++;
      $display("FAIL b2b_count: retired=%0d accepted=%0d, required 8 and 8", outCount, accepts);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (wbLog[i] !== expWb[i]) begin
        fails++;
        $display("FAIL b2b_wb%0d: wb=%h, required %h", i, wbLog[i], expWb[i]);
      end
    end
    $display("[TB] back-to-back: %0d accepted, %0d retired", accepts, outCount);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_nonmem();
    test_store();
    test_loads();
    test_illegal();
    test_reset_mid_access();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory-access stage that consumes the execute stage's ALU result, store data and control bits. It issues byte/half/word loads and stores to the data memory over a req/ack handshake and stalls execute while an access is outstanding. It delivers aligned, sign- or zero-extended writeback data plus register-write control to the writeback stage.

## Interface
- No parameters; address and data widths are fixed at 32 bits.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute outputs hold a valid instruction this cycle
- in_ready  out  1  stage accepts an instruction; low stalls execute
- alu_result  in  32  memory byte address for loads/stores, else the writeback value
- store_data  in  32  rs2 value for stores
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg  in  1 each  control bits from execute
- in_RegDest  in  5  destination register
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  load data, valid when dmem_ack=1
- dmem_ack  in  1  access complete; ignored when dmem_req=0
- out_valid  out  1  one-cycle pulse per retired instruction
- out_RegWrite  out  1  writeback enable
- out_RegDest  out  5  writeback register
- out_wb_data  out  32  writeback value
- access_err  out  1  one-cycle pulse: misaligned or illegal access, aligned with out_valid

## Operation
- FSM states: IDLE, ACCESS.
- in_ready = (state==IDLE).
- Accept occurs when in_valid & in_ready.
- Non-memory op (MemRead=MemWrite=0), accepted in IDLE:
  - Registers out_wb_data=alu_result, out_RegWrite, out_RegDest and out_valid=1 on the next edge.
  - State remains IDLE.
- Legal memory op, accepted in IDLE:
  - Latches the address, store data, funct3 and control bits.
  - Transitions to ACCESS; dmem_req=1 from the next edge.
- Any of the following is illegal:
  - misaligned access: H/HU with addr[0]=1, W with addr[1:0]≠0;
  - undefined funct3 on a memory op;
  - MemRead and MemWrite both set.
- An illegal op issues no request. On the next edge it drives out_valid=1, access_err=1, out_RegWrite=0, and the state remains IDLE.
- ACCESS state:
  - dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and held stable until dmem_ack.
  - On ack, the stage returns to IDLE and registers the writeback outputs with out_valid=1.
- Store lane placement:
  - Byte: be = 1<<addr[1:0], wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - Word: be = 1111, wdata = data.
- Load extraction: select the byte at addr[1:0] or the half at addr[1]. B/H sign-extend; BU/HU zero-extend.
- out_wb_data = MemToReg ? extended load data : alu_result.
- Stores retire with out_valid=1 and pass in_RegWrite through unchanged (0 from decode).
- Reset values: state=IDLE; dmem_req, dmem_we, out_valid, out_RegWrite and access_err = 0; dmem_addr, dmem_wdata, out_wb_data = 0; dmem_be = 0; out_RegDest = 0.

## Timing
- Non-memory op: accept at edge N, out_valid high during cycle N+1 (1-cycle latency).
- Memory op:
  - Accept at edge N; dmem_req rises at N+1.
  - Earliest ack is in cycle N+1, giving out_valid in N+2 (minimum 2-cycle latency).
  - Each wait cycle adds one cycle.
- The earliest next accept is the cycle in which out_valid is high, since the state is already IDLE. Back-to-back non-memory ops retire one per cycle.
- dmem_req drops on the edge that samples dmem_ack; no second request occurs for the same instruction.
- in_valid while in_ready=0 is not consumed; execute holds its outputs.
- rst asserted mid-ACCESS forces dmem_req=0 immediately and drops the in-flight instruction. An ack arriving after reset is ignored.
- out_valid, access_err and all writeback outputs are registered; no combinational path from dmem_rdata to outputs.

## Structure
- Shared package riscv_pkg:
  - funct3 width codes (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state encoding (ST_IDLE, ST_ACCESS).
- Sub-module mem_align (combinational) holds the lane logic:
  - store: addr[1:0] and funct3 → be and wdata;
  - load: rdata, addr[1:0] and funct3 → extended data;
  - misalign/illegal flag.
- The top level holds the FSM, the input latch and the output registers.

## Test plan
- Non-memory op, alu_result=0x0000_1234, RegWrite=1, RegDest=5 → next cycle out_valid=1, out_wb_data=0x1234, out_RegDest=5, no dmem_req.
- SB at addr 0x103, store_data=0xAABBCCDD, ack after 2 wait cycles:
  - dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD;
  - req held for 3 cycles, in_ready=0 throughout;
  - out_valid one cycle after ack.
- LB at 0x202 with rdata=0x0080_0000 → out_wb_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x202 with rdata=0xBEEF_0000 → 0x0000BEEF.
- LW at 0x101 → no dmem_req; next cycle out_valid=1, access_err=1, out_RegWrite=0.
- rst pulsed while in ACCESS with no ack → dmem_req=0 immediately, in_ready=1 after release, a later stray ack produces no out_valid.
- Alternating non-memory/LW stream with same-cycle ack → no instruction lost or duplicated; out_valid count equals accept count.
